// File: rtl/cpu_pkg.sv
// Shared types for the pipeline memory arbiter: state and grant encodings,
// default bus widths and the grant-priority helper.
package cpu_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        IF_BUSY  = 2'b01,
        MEM_BUSY = 2'b10,
        IF_DROP  = 2'b11
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_IF   = 2'b01,
        GNT_MEM  = 2'b10
    } gnt_e;

    // M wins unless IF has been starved for a full run; if_force implies if_req.
    function automatic gnt_e pick_grant(input logic gnt_pt, input logic m_req,
                                        input logic if_req, input logic if_force);
        if (!gnt_pt)
            return GNT_NONE;
        if (m_req && !if_force)
            return GNT_MEM;
        if (if_req)
            return GNT_IF;
        return GNT_NONE;
    endfunction

endpackage

// File: rtl/pipe_mem_arb_timer.sv
// Watchdog for an outstanding RAM access: counts un-acked request cycles and
// flags Expire on the TIMEOUT-th one.
module pipe_mem_arb_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic Clk,
    input  logic Clrn,
    input  logic Clr,
    input  logic En,
    output logic Expire
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Clear has priority so a fresh grant always starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (Clr)
            cnt_d = '0;
        else if (En)
            cnt_d = cnt_q + CW'(1);
    end

    // Counter register.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // cnt_q holds the number of un-acked cycles already seen, so this cycle is the last allowed.
    assign Expire = En & (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Shares one single-port RAM between instruction fetch and the M stage.
// One access in flight at a time; a new grant can be made in the ack cycle so
// accesses run back-to-back. Fetches cancelled by Flush still finish on the
// RAM side but their data is dropped.
module pipe_mem_arbiter
    import cpu_pkg::*;
#(
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF,
    parameter int MAX_MEM_RUN = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic          Clk,
    input  logic          Clrn,
    input  logic          If_Req,
    input  logic [AW-1:0] If_Addr,
    input  logic          Mem_Rd,
    input  logic          Mem_Wr,
    input  logic [AW-1:0] Mem_Addr,
    input  logic [DW-1:0] Mem_WData,
    input  logic          Flush,
    output logic          Ram_Req,
    output logic          Ram_We,
    output logic [AW-1:0] Ram_Addr,
    output logic [DW-1:0] Ram_WData,
    input  logic [DW-1:0] Ram_RData,
    input  logic          Ram_Ack,
    output logic [DW-1:0] If_Inst,
    output logic          If_Valid,
    output logic [DW-1:0] Mem_RData,
    output logic          Mem_Done,
    output logic          Stall,
    output logic          Err
);
    localparam int RW = $clog2(MAX_MEM_RUN + 1);

    arb_state_e    state_q, state_d;
    logic [RW-1:0] run_q, run_d;
    logic          ram_req_q, ram_req_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic [DW-1:0] if_inst_q, if_inst_d;
    logic          if_valid_q, if_valid_d;
    logic [DW-1:0] mem_rdata_q, mem_rdata_d;
    logic          mem_done_q, mem_done_d;
    logic          err_q, err_d;

    logic gnt_pt, m_req, if_force, expire, tmr_clr, tmr_en;
    gnt_e gnt;

    // Arbitration. The M stage keeps presenting its access while stalled, so
    // that access is excluded both in its own ack cycle and in the Mem_Done
    // cycle; otherwise it would be issued a second time.
    always_comb begin
        gnt_pt   = (state_q == IDLE) | Ram_Ack;
        m_req    = (Mem_Rd | Mem_Wr) & ~mem_done_q & ~((state_q == MEM_BUSY) & Ram_Ack);
        if_force = (run_q == RW'(MAX_MEM_RUN)) & If_Req;
        gnt      = pick_grant(gnt_pt, m_req, If_Req, if_force);
    end

    // Access sequencing: completion/abort of the current access, then any new grant.
    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_inst_d   = if_inst_q;
        if_valid_d  = 1'b0;
        mem_rdata_d = mem_rdata_q;
        mem_done_d  = 1'b0;
        err_d       = err_q;

        if (state_q != IDLE) begin
            if (Ram_Ack) begin
                state_d   = IDLE;
                ram_req_d = 1'b0;
                if (state_q == IF_BUSY && !Flush) begin
                    if_valid_d = 1'b1;
                    if_inst_d  = Ram_RData;
                end
                if (state_q == MEM_BUSY) begin
                    mem_done_d = 1'b1;
                    if (!ram_we_q)
                        mem_rdata_d = Ram_RData;
                end
            end else if (expire) begin
                state_d   = IDLE;
                ram_req_d = 1'b0;
                err_d     = 1'b1;
            end else if (state_q == IF_BUSY && Flush) begin
                state_d = IF_DROP;
            end
        end

        case (gnt)
            GNT_MEM: begin
                state_d     = MEM_BUSY;
                ram_req_d   = 1'b1;
                ram_we_d    = Mem_Wr;
                ram_addr_d  = Mem_Addr;
                ram_wdata_d = Mem_WData;
            end
            GNT_IF: begin
                state_d    = IF_BUSY;
                ram_req_d  = 1'b1;
                ram_we_d   = 1'b0;
                ram_addr_d = If_Addr;
            end
            default: ;
        endcase

        // Run counter only moves at grant points; it measures how long IF has waited.
        if (gnt_pt) begin
            if (!If_Req || gnt == GNT_IF)
                run_d = '0;
            else if (gnt == GNT_MEM && run_q != RW'(MAX_MEM_RUN))
                run_d = run_q + RW'(1);
        end
    end

    // Timer runs while a request is outstanding and restarts on ack, grant or expiry.
    always_comb begin
        tmr_en  = ram_req_q & ~Ram_Ack;
        tmr_clr = Ram_Ack | (gnt != GNT_NONE) | expire;
    end

    pipe_mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .Clk    (Clk),
        .Clrn   (Clrn),
        .Clr    (tmr_clr),
        .En     (tmr_en),
        .Expire (expire)
    );

    // State and registered outputs; reset abandons any access immediately.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q     <= IDLE;
            run_q       <= '0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_inst_q   <= '0;
            if_valid_q  <= 1'b0;
            mem_rdata_q <= '0;
            mem_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_inst_q   <= if_inst_d;
            if_valid_q  <= if_valid_d;
            mem_rdata_q <= mem_rdata_d;
            mem_done_q  <= mem_done_d;
            err_q       <= err_d;
        end
    end

    assign Ram_Req   = ram_req_q;
    assign Ram_We    = ram_we_q;
    assign Ram_Addr  = ram_addr_q;
    assign Ram_WData = ram_wdata_q;
    assign If_Inst   = if_inst_q;
    assign If_Valid  = if_valid_q;
    assign Mem_RData = mem_rdata_q;
    assign Mem_Done  = mem_done_q;
    assign Err       = err_q;
    assign Stall     = (Mem_Rd | Mem_Wr) & ~mem_done_q;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Bench for pipe_mem_arbiter: hand-derived vector table, directed flush /
// timeout / reset sequences, and randomized traffic against a reference model.
module tb_pipe_mem_arbiter;
    localparam int AW = 32, DW = 32, MAX_MEM_RUN = 4, TIMEOUT = 64;

    logic          Clk = 1'b0;
    logic          Clrn;
    logic          If_Req, Mem_Rd, Mem_Wr, Flush, Ram_Ack;
    logic [AW-1:0] If_Addr, Mem_Addr;
    logic [DW-1:0] Mem_WData, Ram_RData;
    logic          Ram_Req, Ram_We, If_Valid, Mem_Done, Stall, Err;
    logic [AW-1:0] Ram_Addr;
    logic [DW-1:0] Ram_WData, If_Inst, Mem_RData;

    always #5 Clk = ~Clk;

    pipe_mem_arbiter #(.AW(AW), .DW(DW), .MAX_MEM_RUN(MAX_MEM_RUN), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Clrn(Clrn), .If_Req(If_Req), .If_Addr(If_Addr),
        .Mem_Rd(Mem_Rd), .Mem_Wr(Mem_Wr), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
        .Flush(Flush), .Ram_Req(Ram_Req), .Ram_We(Ram_We), .Ram_Addr(Ram_Addr),
        .Ram_WData(Ram_WData), .Ram_RData(Ram_RData), .Ram_Ack(Ram_Ack),
        .If_Inst(If_Inst), .If_Valid(If_Valid), .Mem_RData(Mem_RData),
        .Mem_Done(Mem_Done), .Stall(Stall), .Err(Err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference model: which access is outstanding (0 none, 1 fetch, 2 load/store),
    // how long it has waited, and what the pipeline should see next cycle.
    int            m_busy, m_wait, m_run;
    bit            m_drop, m_we, m_req, m_ifv, m_done, m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_inst, m_rdata;

    task automatic model_reset();
        m_busy = 0; m_wait = 0; m_run = 0;
        m_drop = 0; m_we = 0; m_req = 0; m_ifv = 0; m_done = 0; m_err = 0;
        m_addr = '0; m_wdata = '0; m_inst = '0; m_rdata = '0;
    endtask

    task automatic model_step();
        bit gp, mreq, nv, nd;
        gp   = (m_busy == 0) || Ram_Ack;
        mreq = (Mem_Rd || Mem_Wr) && !m_done && !(m_busy == 2 && Ram_Ack);
        nv = 0; nd = 0;
        if (m_busy != 0 && Ram_Ack) begin
            if (m_busy == 1 && !m_drop && !Flush) begin nv = 1; m_inst = Ram_RData; end
            if (m_busy == 2) begin nd = 1; if (!m_we) m_rdata = Ram_RData; end
            m_busy = 0; m_req = 0;
        end else if (m_busy != 0) begin
            m_wait++;
            if (m_wait == TIMEOUT) begin m_err = 1; m_busy = 0; m_req = 0; m_wait = 0; end
            else if (m_busy == 1 && Flush) m_drop = 1;
        end
        if (gp) begin
            if (mreq && !(m_run == MAX_MEM_RUN && If_Req)) begin
                m_busy = 2; m_we = Mem_Wr; m_addr = Mem_Addr; m_wdata = Mem_WData;
                m_req = 1; m_drop = 0; m_wait = 0;
                m_run = If_Req ? ((m_run < MAX_MEM_RUN) ? m_run + 1 : m_run) : 0;
            end else if (If_Req) begin
                m_busy = 1; m_we = 0; m_addr = If_Addr;
                m_req = 1; m_drop = 0; m_wait = 0; m_run = 0;
            end else begin
                m_run = 0;
            end
        end
        m_ifv = nv; m_done = nd;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".req"},   {63'd0, Ram_Req},  {63'd0, m_req});
        chk({tag, ".err"},   {63'd0, Err},      {63'd0, m_err});
        chk({tag, ".ifv"},   {63'd0, If_Valid}, {63'd0, m_ifv});
        chk({tag, ".done"},  {63'd0, Mem_Done}, {63'd0, m_done});
        chk({tag, ".mrd"},   {32'd0, Mem_RData}, {32'd0, m_rdata});
        if (m_req) begin
            chk({tag, ".addr"}, {32'd0, Ram_Addr}, {32'd0, m_addr});
            chk({tag, ".we"},   {63'd0, Ram_We},   {63'd0, m_we});
            if (m_we) chk({tag, ".wd"}, {32'd0, Ram_WData}, {32'd0, m_wdata});
        end
        if (m_ifv) chk({tag, ".inst"}, {32'd0, If_Inst}, {32'd0, m_inst});
    endtask

    // One clock: inputs already driven just after a falling edge.
    task automatic run_cyc(input string tag);
        #1;
        chk({tag, ".stall"}, {63'd0, Stall}, {63'd0, (Mem_Rd | Mem_Wr) & ~m_done});
        model_step();
        @(negedge Clk);
        check_all(tag);
    endtask

    task automatic zero_inputs();
        If_Req = 0; If_Addr = '0; Mem_Rd = 0; Mem_Wr = 0; Mem_Addr = '0;
        Mem_WData = '0; Flush = 0; Ram_Ack = 0; Ram_RData = '0;
    endtask

    typedef struct {
        logic        if_req; logic [31:0] if_addr;
        logic        rd; logic wr; logic [31:0] maddr; logic [31:0] wdata;
        logic        ack; logic [31:0] rdata;
        logic        e_stall; logic e_req; logic e_we; logic [31:0] e_addr;
        logic        e_ifv; logic [31:0] e_inst; logic e_done; logic [31:0] e_mrd;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    initial begin
        // fetch alone; M beats IF then fetch back-to-back; store keeps Mem_RData; no re-issue in Done cycle
        tbl[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h10,  1'b0, 32'h0,        1'b0, 32'h0};
        tbl[1] = '{1'b0, 32'h10, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h20080005, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h20080005, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 32'h14, 1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0,        1'b0, 32'h0};
        tbl[3] = '{1'b1, 32'h14, 1'b1, 1'b0, 32'h100, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h14,  1'b0, 32'h0,        1'b1, 32'hDEADBEEF};
        tbl[4] = '{1'b1, 32'h14, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h14,  1'b0, 32'h0,        1'b0, 32'hDEADBEEF};
        tbl[5] = '{1'b0, 32'h14, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h8C090004, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8C090004, 1'b0, 32'hDEADBEEF};
        tbl[6] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h200, 32'h12345678, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF};
        tbl[7] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h200, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 32'hDEADBEEF};
        tbl[8] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h200, 32'h12345678, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 32'hDEADBEEF};
        tbl[9] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 32'hDEADBEEF};

        // Reset state
        Clrn = 0; zero_inputs(); model_reset();
        repeat (2) @(negedge Clk);
        chk("rst.req",  {63'd0, Ram_Req},  64'd0);
        chk("rst.we",   {63'd0, Ram_We},   64'd0);
        chk("rst.addr", {32'd0, Ram_Addr}, 64'd0);
        chk("rst.ifv",  {63'd0, If_Valid}, 64'd0);
        chk("rst.done", {63'd0, Mem_Done}, 64'd0);
        chk("rst.err",  {63'd0, Err},      64'd0);
        chk("rst.stall",{63'd0, Stall},    64'd0);
        Clrn = 1;

        // Vector table
        for (int i = 0; i < 10; i++) begin
            If_Req = tbl[i].if_req; If_Addr = tbl[i].if_addr; Mem_Rd = tbl[i].rd; Mem_Wr = tbl[i].wr;
            Mem_Addr = tbl[i].maddr; Mem_WData = tbl[i].wdata; Ram_Ack = tbl[i].ack; Ram_RData = tbl[i].rdata;
            Flush = 0;
            #1;
            chk($sformatf("tbl%0d.stall", i), {63'd0, Stall}, {63'd0, tbl[i].e_stall});
            model_step();
            @(negedge Clk);
            check_all($sformatf("tbl%0d.m", i));
            chk($sformatf("tbl%0d.req", i),  {63'd0, Ram_Req},  {63'd0, tbl[i].e_req});
            chk($sformatf("tbl%0d.ifv", i),  {63'd0, If_Valid}, {63'd0, tbl[i].e_ifv});
            chk($sformatf("tbl%0d.done", i), {63'd0, Mem_Done}, {63'd0, tbl[i].e_done});
            chk($sformatf("tbl%0d.mrd", i),  {32'd0, Mem_RData}, {32'd0, tbl[i].e_mrd});
            if (tbl[i].e_req) begin
                chk($sformatf("tbl%0d.addr", i), {32'd0, Ram_Addr}, {32'd0, tbl[i].e_addr});
                chk($sformatf("tbl%0d.we", i),   {63'd0, Ram_We},   {63'd0, tbl[i].e_we});
                if (tbl[i].e_we) chk($sformatf("tbl%0d.wd", i), {32'd0, Ram_WData}, {32'd0, tbl[i].wdata});
            end
            if (tbl[i].e_ifv) chk($sformatf("tbl%0d.inst", i), {32'd0, If_Inst}, {32'd0, tbl[i].e_inst});
        end

        // Flush one cycle before the ack: data dropped, request held, next fetch normal
        zero_inputs(); If_Req = 1; If_Addr = 32'h40;
        run_cyc("fl.g");
        If_Req = 0;
        run_cyc("fl.w");
        Flush = 1;
        run_cyc("fl.f");
        chk("fl.hold", {63'd0, Ram_Req}, 64'd1);
        Flush = 0; Ram_Ack = 1; Ram_RData = 32'hAAAA5555;
        run_cyc("fl.a");
        chk("fl.noval", {63'd0, If_Valid}, 64'd0);
        Ram_Ack = 0; If_Req = 1; If_Addr = 32'h80;
        run_cyc("fl.g2");
        chk("fl.addr2", {32'd0, Ram_Addr}, 64'h80);
        If_Req = 0; Ram_Ack = 1; Ram_RData = 32'h11112222;
        run_cyc("fl.a2");
        chk("fl.val2", {63'd0, If_Valid}, 64'd1);
        chk("fl.inst2", {32'd0, If_Inst}, 64'h11112222);

        // Timeout during a load
        zero_inputs(); Mem_Rd = 1; Mem_Addr = 32'h300;
        run_cyc("to.g");
        for (int k = 1; k <= TIMEOUT; k++) begin
            run_cyc("to.w");
            if (k < TIMEOUT) chk("to.held", {63'd0, Ram_Req}, 64'd1);
        end
        chk("to.req0", {63'd0, Ram_Req}, 64'd0);
        chk("to.err",  {63'd0, Err},     64'd1);
        chk("to.nodone", {63'd0, Mem_Done}, 64'd0);
        #1 chk("to.stall", {63'd0, Stall}, 64'd1);
        run_cyc("to.re");
        Ram_Ack = 1; Ram_RData = 32'h0BADF00D;
        run_cyc("to.ack");
        zero_inputs();
        repeat (3) run_cyc("to.idle");
        chk("to.sticky", {63'd0, Err}, 64'd1);
        Clrn = 0; #1;
        chk("to.clr", {63'd0, Err}, 64'd0);
        model_reset();
        @(negedge Clk); Clrn = 1;

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            int r;
            r = $urandom_range(0, 99);
            If_Req    = ($urandom_range(0, 99) < 60);
            If_Addr   = AW'($urandom_range(0, 255) * 4);
            Mem_Rd    = (r < 25);
            Mem_Wr    = (r >= 20 && r < 40);
            Mem_Addr  = AW'($urandom_range(0, 1023) * 4);
            Mem_WData = $urandom();
            Flush     = ($urandom_range(0, 99) < 15);
            Ram_Ack   = m_req ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 10);
            Ram_RData = $urandom();
            run_cyc("rnd");
        end

        // Drain, then reset in the middle of a store
        zero_inputs();
        for (int k = 0; k < 4; k++) begin
            Ram_Ack = m_req;
            run_cyc("drn");
        end
        zero_inputs(); Mem_Wr = 1; Mem_Addr = 32'h400; Mem_WData = 32'hCAFE0001;
        run_cyc("ra.g");
        chk("ra.pre", {63'd0, Ram_Req}, 64'd1);
        #2; Clrn = 0; Mem_Wr = 0; #1;
        chk("ra.req",  {63'd0, Ram_Req},   64'd0);
        chk("ra.we",   {63'd0, Ram_We},    64'd0);
        chk("ra.addr", {32'd0, Ram_Addr},  64'd0);
        chk("ra.wd",   {32'd0, Ram_WData}, 64'd0);
        chk("ra.mrd",  {32'd0, Mem_RData}, 64'd0);
        chk("ra.inst", {32'd0, If_Inst},   64'd0);
        chk("ra.stall",{63'd0, Stall},     64'd0);
        model_reset();
        @(negedge Clk); Clrn = 1;
        run_cyc("ra.idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_mem_arbiter.md
Name: pipe_mem_arbiter

Overview:
- Shares one single-port instruction/data RAM between the IF stage (instruction fetch) and the M stage (lw/sw) of the 5-stage pipeline.
- Sequences each RAM access with a registered request/ack handshake.
- Returns fetched instructions and load data to the pipeline.
- Raises Stall to freeze IF..M while an M-stage access is outstanding.
- Cancels in-flight fetches on a taken branch (Flush, driven from condep).

Parameters:
AW, 32, address width
DW, 32, data width
MAX_MEM_RUN, 4, consecutive M grants allowed while If_Req waits before IF is forced
TIMEOUT, 64, cycles a RAM access may stay unacknowledged before abort

Ports:
Clk  in  1  clock, rising edge
Clrn  in  1  asynchronous active-low reset
If_Req  in  1  IF stage wants an instruction
If_Addr  in  AW  fetch address (PC)
Mem_Rd  in  1  M stage holds a lw
Mem_Wr  in  1  M stage holds a sw
Mem_Addr  in  AW  data address
Mem_WData  in  DW  store data
Flush  in  1  taken branch; discard any fetch in flight
Ram_Req  out  1  access valid, held until Ram_Ack
Ram_We  out  1  write access
Ram_Addr  out  AW  latched access address
Ram_WData  out  DW  latched store data
Ram_RData  in  DW  read data, valid with Ram_Ack
Ram_Ack  in  1  one-cycle completion pulse
If_Inst  out  DW  fetched instruction
If_Valid  out  1  one-cycle pulse, If_Inst valid
Mem_RData  out  DW  load data
Mem_Done  out  1  one-cycle pulse, M access complete
Stall  out  1  freeze IF/ID/E/M pipeline registers
Err  out  1  sticky timeout flag

Behaviour:
- Reset (Clrn=0, asynchronous): state IDLE; all outputs 0; run and timeout counters 0; Err 0.
- States:
  - IDLE: no access in flight.
  - IF_BUSY: fetch in flight.
  - MEM_BUSY: load/store in flight.
  - IF_DROP: flushed fetch in flight; result discarded.
- Grant decision is made in IDLE, or in any BUSY/DROP state in the Ram_Ack cycle, so back-to-back accesses are possible.
- Grant priority:
  - M request (Mem_Rd|Mem_Wr, and Mem_Done=0) beats IF.
  - Exception: if the run counter equals MAX_MEM_RUN and If_Req=1, IF wins.
- On grant:
  - Next cycle: Ram_Req=1.
  - Ram_Addr/Ram_WData/Ram_We are latched from the winner and held stable until Ram_Ack.
  - Ram_We=1 only for Mem_Wr.
  - Mem_Rd and Mem_Wr together is treated as a write.
- Run counter:
  - +1 (saturating at MAX_MEM_RUN) on each M grant while If_Req=1.
  - Cleared on an IF grant, and when If_Req=0 at a grant point.
- Ram_Ack in IF_BUSY: next cycle If_Valid=1 and If_Inst=Ram_RData, unless Flush was seen during the access (state IF_DROP) or Flush=1 in the ack cycle. In either case If_Valid stays 0.
- Ram_Ack in MEM_BUSY: next cycle Mem_Done=1. Mem_RData is loaded for reads; on writes it keeps its old value.
- Stall = (Mem_Rd|Mem_Wr) & ~Mem_Done (combinational).
  - Latency: minimum 2 cycles from M request to Mem_Done with a zero-wait RAM.
  - In the Mem_Done cycle the M request is ignored for granting, so the same access is never re-issued.
- Flush:
  - In IF_BUSY: move to IF_DROP; Ram_Req stays high until Ram_Ack, because the RAM cycle is never aborted.
  - In IDLE: no effect beyond an If_Req arriving that cycle being granted normally, since the PC is already redirected.
- Timeout:
  - Counter increments each cycle Ram_Req=1 without Ram_Ack; cleared on Ram_Ack or a new grant.
  - When it reaches TIMEOUT: Err=1 (sticky until reset), Ram_Req drops, state returns to IDLE, no Valid/Done pulse is issued.
  - Stall therefore remains asserted for the M stage until it re-requests and completes.
- Ram_Ack while IDLE: ignored.
- Reset mid-access: the access is abandoned immediately; the RAM is expected to be reset by the same Clrn.

Decomposition:
- Shared package cpu_pkg holds:
  - state encodings (IDLE=2'b00, IF_BUSY=2'b01, MEM_BUSY=2'b10, IF_DROP=2'b11);
  - grant codes (GNT_NONE, GNT_IF, GNT_MEM);
  - the AW/DW defaults.
- One natural sub-module: pipe_mem_arb_timer, the timeout counter with Clr/En inputs and an Expire output.

Test Plan:
- If_Req=1 alone, If_Addr=0x10, Ram_Ack the cycle after Ram_Req, RData=0x20080005 -> Ram_Addr=0x10 one cycle after request; If_Valid pulses with If_Inst=0x20080005 two cycles after request.
- If_Req and Mem_Rd both high, Mem_Addr=0x100 -> M granted first (Ram_Addr=0x100, Ram_We=0); Stall=1 until the Mem_Done pulse; fetch is granted in the Ram_Ack cycle and issued back-to-back.
- Mem_Wr=1 on 5 consecutive instructions while If_Req=1 -> grants M,M,M,M,IF,M; the run counter clears after the IF grant.
- Fetch in flight, Flush=1 one cycle before Ram_Ack -> state IF_DROP, Ram_Req held to Ack, If_Valid never asserts; the next If_Req is granted normally.
- Ram_Ack withheld for 64 cycles during MEM_BUSY -> Err=1, Ram_Req=0, Stall stays 1; Err holds until Clrn pulses low.
- Clrn low mid MEM_BUSY -> all outputs 0 asynchronously; IDLE after release.
